// File: rtl/pipe_ctrl_stage_if.sv
// Pipeline-boundary bundle: upstream control/payload in, final-slot outputs and perf counters out.
// The master side drives the stage inputs; the slave side is the stage itself.
interface pipe_ctrl_stage_if #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              stall_i;
  logic              flush_i;
  logic              cnt_clr_i;
  logic              valid_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output stall_i, flush_i, cnt_clr_i, valid_i, ctrl_i, data_i,
    input  valid_o, ctrl_o, data_o, stall_cnt_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, cnt_clr_i, valid_i, ctrl_i, data_i,
    output valid_o, ctrl_o, data_o, stall_cnt_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_stage.sv
// DEPTH-slot pipeline register for {valid, ctrl, data} with stall, flush and
// saturating stall/bubble counters; outputs come straight from the last slot.
module pipe_ctrl_stage #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_ctrl_stage_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_SHIFT,
    MODE_HOLD,
    MODE_FLUSH
  } mode_e;

  mode_e mode;

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  // Chain index 0 is the incoming instruction, index k+1 is slot k; a shift
  // loads slots from the low DEPTH entries, which also covers DEPTH=1.
  logic [DEPTH:0]             valid_chain;
  logic [DEPTH:0][CTRL_W-1:0] ctrl_chain;
  logic [DEPTH:0][DATA_W-1:0] data_chain;

  logic [CTRL_W-1:0] ctrl_in;
  logic              stall_inc;
  logic              bubble_inc;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  always_comb begin
    mode = MODE_SHIFT;
    if (bus.flush_i) begin
      mode = MODE_FLUSH;
    end else if (bus.stall_i) begin
      mode = MODE_HOLD;
    end
  end

  // A bubble never enters with live control bits.
  assign ctrl_in     = bus.valid_i ? bus.ctrl_i : '0;
  assign valid_chain = {valid_q, bus.valid_i};
  assign ctrl_chain  = {ctrl_q, ctrl_in};
  assign data_chain  = {data_q, bus.data_i};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      unique case (mode)
        MODE_FLUSH: begin
          valid_q <= '0;
          ctrl_q  <= '0;
        end
        MODE_HOLD: begin
        end
        default: begin
          valid_q <= valid_chain[DEPTH-1:0];
          ctrl_q  <= ctrl_chain[DEPTH-1:0];
          data_q  <= data_chain[DEPTH-1:0];
        end
      endcase
    end
  end

  assign stall_inc  = bus.stall_i & ~bus.flush_i;
  assign bubble_inc = ~bus.stall_i & ~valid_q[DEPTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (bus.cnt_clr_i) begin
      stall_cnt_q <= '0;
    end else if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else if (bus.cnt_clr_i) begin
      bubble_cnt_q <= '0;
    end else if (bubble_inc && (bubble_cnt_q != '1)) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign bus.valid_o      = valid_q[DEPTH-1];
  assign bus.ctrl_o       = ctrl_q[DEPTH-1];
  assign bus.data_o       = data_q[DEPTH-1];
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Bench for pipe_ctrl_stage: three instances (DEPTH 1/2/3, one with 4-bit counters)
// share one stimulus stream and are checked against per-instance slot queues.
module tb_pipe_ctrl_stage;

  typedef struct packed {
    logic        v;
    logic [3:0]  c;
    logic [31:0] d;
  } slot_t;

  typedef struct {
    bit          stall;
    bit          flush;
    bit          clr;
    bit          vld;
    logic [3:0]  ctrl;
    logic [31:0] data;
    bit          ev;
    logic [3:0]  ec;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stall, flush, clr, vin;
  logic [3:0]  cin;
  logic [31:0] din;

  pipe_ctrl_stage_if #(.CTRL_W(4), .DATA_W(32), .CNT_W(16)) b1 ();
  pipe_ctrl_stage_if #(.CTRL_W(4), .DATA_W(32), .CNT_W(4))  b2 ();
  pipe_ctrl_stage_if #(.CTRL_W(4), .DATA_W(32), .CNT_W(16)) b3 ();

  assign b1.stall_i = stall;  assign b2.stall_i = stall;  assign b3.stall_i = stall;
  assign b1.flush_i = flush;  assign b2.flush_i = flush;  assign b3.flush_i = flush;
  assign b1.cnt_clr_i = clr;  assign b2.cnt_clr_i = clr;  assign b3.cnt_clr_i = clr;
  assign b1.valid_i = vin;    assign b2.valid_i = vin;    assign b3.valid_i = vin;
  assign b1.ctrl_i = cin;     assign b2.ctrl_i = cin;     assign b3.ctrl_i = cin;
  assign b1.data_i = din;     assign b2.data_i = din;     assign b3.data_i = din;

  pipe_ctrl_stage #(.CTRL_W(4), .DATA_W(32), .DEPTH(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(rst), .bus(b1));
  pipe_ctrl_stage #(.CTRL_W(4), .DATA_W(32), .DEPTH(2), .CNT_W(4)) u2 (
    .clk(clk), .reset(rst), .bus(b2));
  pipe_ctrl_stage #(.CTRL_W(4), .DATA_W(32), .DEPTH(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(rst), .bus(b3));

  logic        ov  [3];
  logic [3:0]  oc  [3];
  logic [31:0] od  [3];
  logic [15:0] osc [3];
  logic [15:0] obc [3];

  assign ov[0] = b1.valid_o;  assign ov[1] = b2.valid_o;  assign ov[2] = b3.valid_o;
  assign oc[0] = b1.ctrl_o;   assign oc[1] = b2.ctrl_o;   assign oc[2] = b3.ctrl_o;
  assign od[0] = b1.data_o;   assign od[1] = b2.data_o;   assign od[2] = b3.data_o;
  assign osc[0] = b1.stall_cnt_o;
  assign osc[1] = {12'd0, b2.stall_cnt_o};
  assign osc[2] = b3.stall_cnt_o;
  assign obc[0] = b1.bubble_cnt_o;
  assign obc[1] = {12'd0, b2.bubble_cnt_o};
  assign obc[2] = b3.bubble_cnt_o;

  // Each queue holds one entry per slot, oldest (output slot) at the front.
  slot_t sb [3][$];
  int    dep  [3] = '{1, 2, 3};
  int    cmax [3] = '{65535, 15, 65535};
  int    scnt [3];
  int    bcnt [3];

  int checks = 0;
  int errors = 0;

  vec_t tbl [18];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      sb[u].delete();
      for (int k = 0; k < dep[u]; k++) sb[u].push_back('0);
      scnt[u] = 0;
      bcnt[u] = 0;
    end
  endtask

  task automatic model_step();
    slot_t s;
    for (int u = 0; u < 3; u++) begin
      if (clr) begin
        scnt[u] = 0;
        bcnt[u] = 0;
      end else begin
        if (stall && !flush && scnt[u] < cmax[u]) scnt[u]++;
        if (!stall && !sb[u][0].v && bcnt[u] < cmax[u]) bcnt[u]++;
      end
      if (flush) begin
        for (int k = 0; k < dep[u]; k++) begin
          s = sb[u][k];
          s.v = 1'b0;
          s.c = 4'h0;
          sb[u][k] = s;
        end
      end else if (!stall) begin
        void'(sb[u].pop_front());
        s.v = vin;
        s.c = vin ? cin : 4'h0;
        s.d = din;
        sb[u].push_back(s);
      end
    end
  endtask

  task automatic check_all();
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("d%0d valid_o", dep[u]), 64'(ov[u]), 64'(sb[u][0].v));
      chk($sformatf("d%0d ctrl_o", dep[u]), 64'(oc[u]), 64'(sb[u][0].c));
      chk($sformatf("d%0d data_o", dep[u]), 64'(od[u]), 64'(sb[u][0].d));
      chk($sformatf("d%0d stall_cnt_o", dep[u]), 64'(osc[u]), 64'(scnt[u]));
      chk($sformatf("d%0d bubble_cnt_o", dep[u]), 64'(obc[u]), 64'(bcnt[u]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit s, input bit f, input bit cl, input bit v,
                       input logic [3:0] c, input logic [31:0] d);
    stall = s; flush = f; clr = cl; vin = v; cin = c; din = d;
  endtask

  initial begin
    //            stall flush clr vld ctrl  data          ev ec
    tbl[0]  = '{0, 0, 0, 1, 4'h1, 32'h0000_0011, 1, 4'h1};
    tbl[1]  = '{0, 0, 0, 1, 4'h2, 32'h0000_0022, 1, 4'h2};
    tbl[2]  = '{0, 0, 0, 1, 4'h3, 32'h0000_0033, 1, 4'h3};
    tbl[3]  = '{0, 0, 0, 1, 4'h4, 32'h0000_0044, 1, 4'h4};
    tbl[4]  = '{0, 0, 0, 0, 4'hF, 32'h0000_0055, 0, 4'h0};
    tbl[5]  = '{0, 0, 0, 0, 4'hF, 32'h0000_0056, 0, 4'h0};
    tbl[6]  = '{0, 0, 0, 1, 4'h5, 32'h0000_0066, 1, 4'h5};
    tbl[7]  = '{1, 0, 0, 1, 4'h6, 32'h0000_0067, 1, 4'h5};
    tbl[8]  = '{1, 0, 0, 0, 4'h7, 32'h0000_0068, 1, 4'h5};
    tbl[9]  = '{1, 0, 0, 1, 4'h8, 32'h0000_0069, 1, 4'h5};
    tbl[10] = '{0, 0, 0, 1, 4'h6, 32'h0000_0077, 1, 4'h6};
    tbl[11] = '{0, 0, 0, 1, 4'hF, 32'h0000_0088, 1, 4'hF};
    tbl[12] = '{0, 0, 0, 1, 4'hF, 32'h0000_0099, 1, 4'hF};
    tbl[13] = '{0, 0, 0, 1, 4'hF, 32'h0000_00AA, 1, 4'hF};
    tbl[14] = '{1, 1, 0, 1, 4'h3, 32'h0000_00AB, 0, 4'h0};
    tbl[15] = '{0, 0, 0, 1, 4'h9, 32'h0000_00BB, 1, 4'h9};
    tbl[16] = '{0, 0, 1, 1, 4'hA, 32'h0000_00CC, 1, 4'hA};
    tbl[17] = '{0, 1, 0, 1, 4'hC, 32'h0000_00DD, 0, 4'h0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 4'h0, 32'h0);
    model_reset();
    cycle();
    cycle();
    #3;
    rst = 1'b0;

    // Fill with live values, then reset asynchronously between edges.
    drive(0, 0, 0, 1, 4'hF, 32'hFFFF_FFFF);
    repeat (3) cycle();
    #1;
    drive(1, 1, 1, 1, 4'hF, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("async d%0d valid_o", dep[u]), 64'(ov[u]), 64'd0);
      chk($sformatf("async d%0d ctrl_o", dep[u]), 64'(oc[u]), 64'd0);
      chk($sformatf("async d%0d data_o", dep[u]), 64'(od[u]), 64'd0);
      chk($sformatf("async d%0d stall_cnt_o", dep[u]), 64'(osc[u]), 64'd0);
      chk($sformatf("async d%0d bubble_cnt_o", dep[u]), 64'(obc[u]), 64'd0);
    end
    model_reset();
    #1;
    rst = 1'b0;
    drive(0, 0, 0, 1, 4'hB, 32'hDEAD_BEEF);
    cycle();
    chk("first capture valid_o", 64'(b1.valid_o), 64'd1);
    chk("first capture ctrl_o", 64'(b1.ctrl_o), 64'hB);
    chk("first capture data_o", 64'(b1.data_o), 64'hDEAD_BEEF);

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].clr, tbl[i].vld, tbl[i].ctrl, tbl[i].data);
      cycle();
      chk($sformatf("vec%0d d1 valid_o", i), 64'(b1.valid_o), 64'(tbl[i].ev));
      chk($sformatf("vec%0d d1 ctrl_o", i), 64'(b1.ctrl_o), 64'(tbl[i].ec));
    end

    // Long stall saturates the 4-bit counter; clear wins over a same-cycle stall.
    drive(1, 0, 0, 1, 4'h1, 32'h1234_5678);
    repeat (20) cycle();
    chk("sat stall_cnt_o", 64'(b2.stall_cnt_o), 64'd15);
    drive(1, 0, 1, 1, 4'h1, 32'h1234_5678);
    cycle();
    chk("clr stall_cnt_o", 64'(b2.stall_cnt_o), 64'd0);

    for (int n = 0; n < 60; n++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
            4'($urandom), 32'($urandom));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_stage.md
# pipe_ctrl_stage

Parametrised pipeline-boundary register for the pipelined RISC-V core, carrying per-instruction control bits plus an optional datapath payload through DEPTH register slots. Adds stall (hold), flush (bubble insertion with control zeroing), per-slot valid tracking and saturating stall/bubble performance counters. Instantiated between pipeline stages (ID/EX, EX/MEM, MEM/WB) in place of fixed-width per-stage control registers.

## Interface
- CTRL_W, 4, width of control bundle (e.g. RegWrite, MemWrite, ResultSrc[1:0])
- DATA_W, 32, width of datapath payload; legal range 1..64
- DEPTH, 1, number of register slots in the chain; legal range 1..4
- CNT_W, 16, width of each performance counter

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- stall_i  input  1  hold all slots this cycle
- flush_i  input  1  invalidate all slots this cycle
- cnt_clr_i  input  1  synchronous clear of both counters
- valid_i  input  1  incoming instruction is real
- ctrl_i  input  CTRL_W  incoming control bundle
- data_i  input  DATA_W  incoming payload
- valid_o  output  1  valid bit of final slot
- ctrl_o  output  CTRL_W  control bundle of final slot
- data_o  output  DATA_W  payload of final slot
- stall_cnt_o  output  CNT_W  cycles with stall_i=1 and flush_i=0
- bubble_cnt_o  output  CNT_W  cycles with valid_o=0 and no stall

## Operation
- Slots S0..S(DEPTH-1); S0 loads from inputs, Sk loads from S(k-1); outputs driven directly from S(DEPTH-1) registers (no combinational path input-to-output).
- Each slot holds {valid, ctrl, data}.
- Priority per cycle: reset > flush_i > stall_i > normal shift.
- Normal (stall_i=0, flush_i=0): all slots shift one position; S0 captures valid_i, and ctrl_i if valid_i=1 else all-zeros; data_i captured unconditionally.
- Stall (stall_i=1, flush_i=0): every slot holds its value; inputs ignored.
- Flush (flush_i=1, any stall_i): every slot valid<=0 and ctrl<=0; data fields hold. Incoming valid_i/ctrl_i that cycle is discarded.
- Invariant: a slot with valid=0 always has ctrl=0, so downstream write enables are never asserted for a bubble.
- Counters saturate at 2^CNT_W-1 (no wrap). cnt_clr_i sets both to 0 and overrides increment in the same cycle.
- stall_cnt increments when stall_i=1 and flush_i=0.
- bubble_cnt increments when stall_i=0 and the current (pre-edge) valid_o=0.

## Timing
- Reset values: valid_o=0, ctrl_o=0, data_o=0, stall_cnt_o=0, bubble_cnt_o=0; all internal slots zero.
- Reset is asynchronous assert; outputs go to zero without a clock edge. Deassertion is sampled on the next rising edge; first capture on that edge.
- Latency: input presented at edge N appears at outputs after edge N+DEPTH-1 (i.e. DEPTH edges including the capture edge), extended by one cycle per stalled cycle in between.
- Throughput: one instruction per unstalled cycle.
- Flush takes effect at the edge on which it is sampled; valid_o=0 and ctrl_o=0 from that edge onward until new valid data reaches the last slot (DEPTH edges later at earliest).
- Reset mid-stall or mid-flush: reset wins, all state zero, counters zero.
- Stall with valid_i toggling: no change to any slot; valid_i pulse during stall is lost (upstream must also stall).

## Test plan
- Reset: drive all inputs nonzero, assert reset asynchronously between edges -> all outputs 0 immediately; after release with DEPTH=1, valid_i=1, ctrl_i=4'b1011, data_i=32'hDEADBEEF -> outputs show those values after next edge.
- Latency DEPTH=3: stream valid instructions ctrl=1,2,3,4 on consecutive cycles -> ctrl_o shows 1 after the third edge, then 2,3,4 on successive edges, valid_o=1 throughout.
- Stall: DEPTH=2, stream ctrl=5,6, stall_i=1 for 3 cycles mid-stream -> outputs frozen 3 cycles, stall_cnt_o=3, sequence resumes without loss or duplication.
- Flush with control zeroing: pipeline full of valid ctrl=4'hF, assert flush_i and stall_i together one cycle -> next edge valid_o=0, ctrl_o=0, data_o unchanged; stall_cnt_o unchanged.
- Invalid input gating: valid_i=0 with ctrl_i=4'hF -> ctrl_o=0 when that slot reaches output; bubble_cnt_o increments each unstalled cycle valid_o=0.
- Counter saturation/clear: CNT_W=4, hold stall_i=1 for 20 cycles -> stall_cnt_o stops at 15; assert cnt_clr_i with stall_i=1 -> stall_cnt_o=0 next edge.
